// File: rtl/matrix_pkg.sv
// ============================================================================
//  Module      : matrix_pkg
//  Description : Shared constants and the loader state encoding for the 5x5
//                matrix datapath (loader, sum controller, readback logic).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_pkg;

    localparam int ELEM_W     = 8;
    localparam int MATRIX_DIM = 5;
    localparam int ELEMS      = MATRIX_DIM * MATRIX_DIM;

    // Fixed RAM slots for the operands and the result.
    localparam int ADDR_A = 0;
    localparam int ADDR_B = 1;
    localparam int ADDR_C = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/matrix_loader_if.sv
// ============================================================================
//  Module      : matrix_loader_if
//  Description : Bundles the loader's control, element-stream and RAM write
//                signals.
//                  start, in_data, in_valid        -> loader
//                  in_ready, mem_address, mem_data,
//                  mem_wren, busy, done            <- loader
//                master : the side feeding elements and observing the RAM port
//                slave  : the loader itself
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matrix_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 256,
    parameter int ELEM_W = 8
);
    logic              start;
    logic [ELEM_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic              busy;
    logic              done;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_address, mem_data, mem_wren, busy, done
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_address, mem_data, mem_wren, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/matrix_loader_element_packer.sv
// ============================================================================
//  Module      : element_packer
//  Description : Packs ELEMS elements of ELEM_W bits into one flat buffer,
//                element 0 in the least significant slot.
//                  i_clear      : zero the buffer and the element count
//                  i_wr_en      : store i_wr_data at the current count
//                  o_buf_next   : buffer contents including this cycle's write
//                  o_full       : the current write fills the final slot
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module element_packer #(
    parameter int ELEM_W = 8,
    parameter int ELEMS  = 25
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    input  wire logic                      i_clear,
    input  wire logic                      i_wr_en,
    input  wire logic [ELEM_W-1:0]         i_wr_data,
    output logic      [ELEMS*ELEM_W-1:0]   o_buf_next,
    output logic                           o_full
);
    localparam int CNT_W = $clog2(ELEMS + 1);

    logic [ELEMS*ELEM_W-1:0] r_buf;
    logic [CNT_W-1:0]        r_cnt;
    logic [ELEMS*ELEM_W-1:0] w_buf_next;

    // The look-ahead image lets the owner capture a complete word on the
    // same edge that accepts the final element.
    always_comb begin
        w_buf_next = r_buf;
        if (i_wr_en) begin
            w_buf_next[ELEM_W*r_cnt +: ELEM_W] = i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_wr_en) begin
            r_buf <= w_buf_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_buf_next = w_buf_next;
    assign o_full     = (r_cnt == CNT_W'(ELEMS - 1));

endmodule

`default_nettype wire

// File: rtl/matrix_loader.sv
// ============================================================================
//  Module      : matrix_loader
//  Description : Writer side of the matrix RAM. Accepts NUM_MATRICES matrices
//                of ELEMS elements over a valid/ready stream, packs each one
//                into a DATA_W word and writes it to BASE_ADDR + index, then
//                pulses done.
//                  clk, reset : clock, synchronous active-high reset
//                  bus        : start/stream inputs, in_ready, RAM write
//                               port, busy and done (all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_loader
    import matrix_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 256,
    parameter int ELEM_W       = matrix_pkg::ELEM_W,
    parameter int ELEMS        = matrix_pkg::ELEMS,
    parameter int NUM_MATRICES = 2,
    parameter int BASE_ADDR    = matrix_pkg::ADDR_A
) (
    input  wire logic         clk,
    input  wire logic         reset,
    matrix_loader_if.slave    bus
);
    localparam int MAT_W = (NUM_MATRICES > 1) ? $clog2(NUM_MATRICES) : 1;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [MAT_W-1:0]        r_mat_idx;
    logic                    r_in_ready;
    logic [ADDR_W-1:0]       r_mem_address;
    logic [DATA_W-1:0]       r_mem_data;
    logic                    r_mem_wren;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_accept;
    logic                    w_full;
    logic                    w_last_mat;
    logic [ELEMS*ELEM_W-1:0] w_buf_next;

    assign w_accept   = bus.in_valid && r_in_ready;
    assign w_last_mat = (r_mat_idx == MAT_W'(NUM_MATRICES - 1));

    // Clearing whenever not filling guarantees every matrix starts from an
    // empty buffer and a zero count, including after a write.
    element_packer #(
        .ELEM_W (ELEM_W),
        .ELEMS  (ELEMS)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (r_state != FILL),
        .i_wr_en    (w_accept),
        .i_wr_data  (bus.in_data),
        .o_buf_next (w_buf_next),
        .o_full     (w_full)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.start)          w_state_next = FILL;
            FILL:    if (w_accept && w_full) w_state_next = WRITE;
            WRITE:   w_state_next = w_last_mat ? DONE : FILL;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so that each one is valid
    // in the same cycle as the state it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_mat_idx     <= '0;
            r_in_ready    <= 1'b0;
            r_mem_address <= ADDR_W'(BASE_ADDR);
            r_mem_data    <= '0;
            r_mem_wren    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == FILL);
            r_mem_wren <= (w_state_next == WRITE);
            r_busy     <= (w_state_next != IDLE);
            r_done     <= (w_state_next == DONE);

            if (r_state == IDLE && bus.start) begin
                r_mat_idx <= '0;
            end else if (r_state == WRITE && !w_last_mat) begin
                r_mat_idx <= r_mat_idx + 1'b1;
            end

            // Address and data are loaded only for a write and otherwise hold.
            if (r_state == FILL && w_accept && w_full) begin
                r_mem_address <= ADDR_W'(BASE_ADDR) + ADDR_W'(r_mat_idx);
                r_mem_data    <= DATA_W'(w_buf_next);
            end
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_data    = r_mem_data;
    assign bus.mem_wren    = r_mem_wren;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_matrix_loader.sv
// ============================================================================
//  Module      : tb_matrix_loader
//  Description : Directed self-checking bench for matrix_loader. A default
//                instance (BASE_ADDR=0, two matrices) and a wrapping instance
//                (BASE_ADDR=254, three matrices) share one stimulus driver;
//                sel chooses which instance is driven and observed.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic drv_start = 1'b0;
    logic drv_valid = 1'b0;
    logic [7:0] drv_data = 8'd0;

    always #5 clk = ~clk;

    matrix_loader_if #(.ADDR_W(8), .DATA_W(256), .ELEM_W(8)) bus1 ();
    matrix_loader_if #(.ADDR_W(8), .DATA_W(256), .ELEM_W(8)) bus2 ();

    assign bus1.start    = drv_start && !sel;
    assign bus1.in_valid = drv_valid && !sel;
    assign bus1.in_data  = drv_data;
    assign bus2.start    = drv_start && sel;
    assign bus2.in_valid = drv_valid && sel;
    assign bus2.in_data  = drv_data;

    matrix_loader u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1)
    );

    matrix_loader #(
        .NUM_MATRICES (3),
        .BASE_ADDR    (254)
    ) u_dut_wrap (
        .clk   (clk),
        .reset (rst),
        .bus   (bus2)
    );

    logic         mon_ready, mon_wren, mon_busy, mon_done;
    logic [7:0]   mon_addr;
    logic [255:0] mon_data;

    assign mon_ready = sel ? bus2.in_ready    : bus1.in_ready;
    assign mon_wren  = sel ? bus2.mem_wren    : bus1.mem_wren;
    assign mon_busy  = sel ? bus2.busy        : bus1.busy;
    assign mon_done  = sel ? bus2.done        : bus1.done;
    assign mon_addr  = sel ? bus2.mem_address : bus1.mem_address;
    assign mon_data  = sel ? bus2.mem_data    : bus1.mem_data;

    // Observed on the falling edge, half a cycle away from the active edge.
    logic [7:0]   wr_addr[$];
    logic [255:0] wr_data[$];
    int done_cnt  = 0;
    int acc_cnt   = 0;
    int ready_bad = 0;

    always @(negedge clk) begin
        if (mon_wren) begin
            wr_addr.push_back(mon_addr);
            wr_data.push_back(mon_data);
        end
        if (mon_done) done_cnt++;
        if (drv_valid && mon_ready) acc_cnt++;
        if (mon_ready && (!mon_busy || mon_wren || mon_done)) ready_bad++;
    end

    int checks   = 0;
    int failures = 0;
    int wb, db, ab;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference word: 25 consecutive byte values starting at 'first'.
    function automatic logic [255:0] pack_seq(input int first);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 25; i++) v[8*i +: 8] = 8'(first + i);
        return v;
    endfunction

    task automatic mark();
        wb = wr_addr.size();
        db = done_cnt;
        ab = acc_cnt;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        drv_start = 1'b1;
        cycle();
        drv_start = 1'b0;
    endtask

    task automatic drive_beat(input logic [7:0] d, input int gap);
        int  n;
        bit  fin;
        drv_valid = 1'b0;
        repeat (gap) cycle();
        drv_data  = d;
        drv_valid = 1'b1;
        n   = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (mon_ready) begin
                cycle();
                fin = 1'b1;
            end else begin
                cycle();
                n++;
                if (n > 200) begin
                    check("beat_timeout", 0, 1);
                    fin = 1'b1;
                end
            end
        end
        drv_valid = 1'b0;
    endtask

    task automatic run_stream(input int first, input int count, input int maxgap);
        for (int i = 0; i < count; i++)
            drive_beat(8'(first + i), (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (done_cnt == db && n < bound) begin
            cycle();
            n++;
        end
        check("done_seen", 256'(done_cnt != db), 1);
        repeat (6) cycle();
    endtask

    task automatic check_reset_outputs(input string tag, input logic [7:0] base);
        check({tag, "_in_ready"}, mon_ready, 0);
        check({tag, "_wren"},     mon_wren,  0);
        check({tag, "_addr"},     mon_addr,  base);
        check({tag, "_data"},     mon_data,  0);
        check({tag, "_busy"},     mon_busy,  0);
        check({tag, "_done"},     mon_done,  0);
    endtask

    task automatic check_ab_session(input string tag, input int first_b);
        check({tag, "_writes"}, wr_addr.size() - wb, 2);
        check({tag, "_addr0"},  wr_addr[wb], 8'd0);
        check({tag, "_a_lo"},   wr_data[wb][7:0], 8'd1);
        check({tag, "_a_hi"},   wr_data[wb][199:192], 8'd25);
        check({tag, "_a_pad"},  wr_data[wb][255:200], 56'd0);
        check({tag, "_a_word"}, wr_data[wb], pack_seq(1));
        check({tag, "_addr1"},  wr_addr[wb+1], 8'd1);
        check({tag, "_b_lo"},   wr_data[wb+1][7:0], 8'(first_b));
        check({tag, "_b_word"}, wr_data[wb+1], pack_seq(first_b));
        check({tag, "_dones"},  done_cnt - db, 1);
        check({tag, "_beats"},  acc_cnt - ab, 50);
        check({tag, "_ready_idle"}, mon_ready, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Reset state
        repeat (3) cycle();
        check_reset_outputs("rst", 8'd0);
        rst = 1'b0;
        cycle();

        // 1: A = 1..25, B = 101..125, no gaps
        mark();
        pulse_start();
        run_stream(1, 25, 0);
        run_stream(101, 25, 0);
        wait_done(100);
        check_ab_session("s1", 101);

        // 2: same data with random valid gaps
        mark();
        pulse_start();
        run_stream(1, 25, 5);
        run_stream(101, 25, 5);
        wait_done(400);
        check_ab_session("s2", 101);
        check("s2_ready_legal", ready_bad, 0);

        // 3: valid held high with 60 bytes queued; only 50 are taken
        mark();
        drv_data  = 8'd1;
        drv_valid = 1'b1;
        pulse_start();
        n = 0;
        while (done_cnt == db && n < 400) begin
            cycle();
            drv_data = 8'(acc_cnt - ab + 1);
            n++;
        end
        repeat (10) begin
            cycle();
            drv_data = 8'(acc_cnt - ab + 1);
        end
        check("s3_beats", acc_cnt - ab, 50);
        check("s3_ready_after", mon_ready, 0);
        check("s3_busy_after", mon_busy, 0);
        check("s3_writes", wr_addr.size() - wb, 2);
        check("s3_b_word", wr_data[wb+1], pack_seq(26));
        check("s3_dones", done_cnt - db, 1);
        drv_valid = 1'b0;
        cycle();

        // 4: start pulsed mid-fill is ignored
        mark();
        pulse_start();
        run_stream(1, 10, 0);
        pulse_start();
        run_stream(11, 40, 0);
        wait_done(100);
        check_ab_session("s4", 26);

        // 5: reset after 30 beats, then a fresh session
        mark();
        pulse_start();
        run_stream(1, 30, 0);
        rst = 1'b1;
        cycle();
        check_reset_outputs("s5", 8'd0);
        repeat (3) cycle();
        check("s5_writes", wr_addr.size() - wb, 1);
        check("s5_addr0", wr_addr[wb], 8'd0);
        rst = 1'b0;
        cycle();
        mark();
        pulse_start();
        run_stream(1, 50, 0);
        wait_done(100);
        check_ab_session("s5_fresh", 26);

        // 6: BASE_ADDR=254, three matrices, address wraps to 0
        rst = 1'b1;
        sel = 1'b1;
        repeat (2) cycle();
        check_reset_outputs("s6_rst", 8'd254);
        rst = 1'b0;
        cycle();
        mark();
        pulse_start();
        run_stream(1, 75, 0);
        wait_done(100);
        check("s6_writes", wr_addr.size() - wb, 3);
        check("s6_addr0", wr_addr[wb],   8'd254);
        check("s6_addr1", wr_addr[wb+1], 8'd255);
        check("s6_addr2", wr_addr[wb+2], 8'd0);
        check("s6_word0", wr_data[wb],   pack_seq(1));
        check("s6_word1", wr_data[wb+1], pack_seq(26));
        check("s6_word2", wr_data[wb+2], pack_seq(51));
        check("s6_dones", done_cnt - db, 1);
        check("ready_legal", ready_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
